// File: rtl/e15_run_controller.sv
// E15 run controller: 16x12 instruction store with a valid/ready loader,
// a free-run/step sequencer and halt/timeout detection.
// Optional breakpoint support is enabled by defining E15_BREAKPOINT_EN.
module e15_run_controller #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned MAX_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [11:0]      load_data,
  input  logic             load_last,
  input  logic             start,
  input  logic             step,
  input  logic             stop,
  input  logic [3:0]       core_pc,
  output logic [11:0]      core_instr,
  output logic             core_en,
  output logic             core_clr,
  output logic [2:0]       state,
  output logic             prog_loaded,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count
`ifdef E15_BREAKPOINT_EN
  ,
  input  logic             bp_valid,
  input  logic [3:0]       bp_addr,
  output logic             bp_hit
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLR   = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       wr_ptr_q, wr_ptr_d;
  logic             load_ready_q, load_ready_d;
  logic             prog_loaded_q, prog_loaded_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [11:0]      mem_q [16];

  logic             load_fire;
  logic             halt;
  logic             timeout_hit;
  logic [3:0]       wr_addr;

`ifdef E15_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;
  logic bp_match;
  assign bp_match = bp_valid && (core_pc == bp_addr);
  assign bp_hit   = bp_hit_q;
`endif

  assign load_fire   = load_valid && load_ready_q;
  assign wr_addr     = (state_q == S_IDLE) ? 4'd0 : wr_ptr_q;
  assign core_instr  = mem_q[core_pc];
  assign halt        = (core_instr[11:8] == 4'b0000) && (core_instr[3:0] == 4'b0000);
  assign timeout_hit = (MAX_CYCLES != 0) && (count_q >= CNT_W'(MAX_CYCLES));

  assign load_ready  = load_ready_q;
  assign prog_loaded = prog_loaded_q;
  assign timeout     = timeout_q;
  assign instr_count = count_q;
  assign state       = state_q;

  // Next-state, loader bookkeeping and core strobes.
  // load_ready is registered so it rises one cycle after entering IDLE; once a
  // program completes it stays low until a DONE -> IDLE return re-opens loading.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    load_ready_d  = 1'b0;
    prog_loaded_d = prog_loaded_q;
    timeout_d     = timeout_q;
    count_d       = count_q;
    core_en       = 1'b0;
    core_clr      = 1'b0;
`ifdef E15_BREAKPOINT_EN
    bp_hit_d      = bp_hit_q;
`endif
    case (state_q)
      S_IDLE: begin
        load_ready_d = load_ready_q;
        if (load_fire) begin
          wr_ptr_d = 4'd1;
          if (load_last) begin
            prog_loaded_d = 1'b1;
            load_ready_d  = 1'b0;
          end else begin
            prog_loaded_d = 1'b0;
            load_ready_d  = 1'b1;
            state_d       = S_LOAD;
          end
        end else if (start && prog_loaded_q) begin
          load_ready_d = 1'b0;
          state_d      = S_CLR;
        end else if (!prog_loaded_q) begin
          load_ready_d = 1'b1;
        end
      end
      S_LOAD: begin
        load_ready_d = 1'b1;
        if (load_fire) begin
          wr_ptr_d = wr_ptr_q + 4'd1;
          if (load_last || (wr_ptr_q == 4'hF)) begin
            prog_loaded_d = 1'b1;
            load_ready_d  = 1'b0;
            state_d       = S_IDLE;
          end
        end
      end
      S_CLR: begin
        core_clr  = 1'b1;
        count_d   = '0;
        timeout_d = 1'b0;
`ifdef E15_BREAKPOINT_EN
        bp_hit_d  = 1'b0;
`endif
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
`ifdef E15_BREAKPOINT_EN
        end else if (bp_match) begin
          bp_hit_d = 1'b1;
          state_d  = S_PAUSE;
`endif
        end else if (stop) begin
          state_d = S_PAUSE;
        end else begin
          core_en = 1'b1;
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_PAUSE;
        end else if (step) begin
`ifdef E15_BREAKPOINT_EN
          bp_hit_d = 1'b0;
`endif
          if (halt) state_d = S_DONE;
          else      core_en = 1'b1;
        end else if (start) begin
`ifdef E15_BREAKPOINT_EN
          bp_hit_d = 1'b0;
`endif
          state_d = S_CLR;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_CLR;
        end else if (load_valid) begin
          load_ready_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (core_en && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      load_ready_q  <= 1'b0;
      prog_loaded_q <= 1'b0;
      timeout_q     <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      load_ready_q  <= load_ready_d;
      prog_loaded_q <= prog_loaded_d;
      timeout_q     <= timeout_d;
      count_q       <= count_d;
    end
  end

`ifdef E15_BREAKPOINT_EN
  // Breakpoint flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bp_hit_q <= 1'b0;
    else        bp_hit_q <= bp_hit_d;
  end
`endif

  // Instruction store: the first word of a new program blanks every entry so
  // short programs fall through to 12'h000 (halt).
  always_ff @(posedge clk) begin
    if (load_fire) begin
      if (state_q == S_IDLE) begin
        for (int unsigned i = 0; i < 16; i++) mem_q[i[3:0]] <= '0;
      end
      mem_q[wr_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_e15_run_controller.sv
// Directed bench for e15_run_controller with a minimal core PC model.
// Define E15_BREAKPOINT_EN to also exercise the breakpoint feature.
module tb_e15_run_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_last = 1'b0;
  logic [11:0] load_data = '0;
  logic        start = 1'b0;
  logic        step = 1'b0;
  logic        stop = 1'b0;
  logic [3:0]  core_pc;
  logic [3:0]  model_pc;
  logic        pc_force = 1'b0;
  logic [3:0]  pc_force_val = '0;

  logic        load_ready;
  logic [11:0] core_instr;
  logic        core_en;
  logic        core_clr;
  logic [2:0]  state;
  logic        prog_loaded;
  logic        timeout;
  logic [7:0]  instr_count;
`ifdef E15_BREAKPOINT_EN
  logic        bp_valid = 1'b0;
  logic [3:0]  bp_addr = '0;
  logic        bp_hit;
`endif

  int checks = 0;
  int errors = 0;

  e15_run_controller #(.CNT_W(8), .MAX_CYCLES(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_last   (load_last),
    .start       (start),
    .step        (step),
    .stop        (stop),
    .core_pc     (core_pc),
    .core_instr  (core_instr),
    .core_en     (core_en),
    .core_clr    (core_clr),
    .state       (state),
    .prog_loaded (prog_loaded),
    .timeout     (timeout),
    .instr_count (instr_count)
`ifdef E15_BREAKPOINT_EN
    ,
    .bp_valid    (bp_valid),
    .bp_addr     (bp_addr),
    .bp_hit      (bp_hit)
`endif
  );

  always #5 clk = ~clk;

  assign core_pc = pc_force ? pc_force_val : model_pc;

  // Minimal core: opcode 0 is a relative jump by imm, everything else falls through.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        model_pc <= '0;
    else if (core_clr) model_pc <= '0;
    else if (core_en)  model_pc <= (core_instr[11:8] == 4'h0) ? model_pc + core_instr[3:0]
                                                               : model_pc + 4'd1;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [11:0] d, input logic last);
    int unsigned n = 0;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    @(negedge clk);
    while (!load_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!load_ready) begin
      errors++;
      $display("FAIL load_wait: load_ready=%0b required 1 within 50 cycles", load_ready);
    end
    cycle();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (state !== 3'd0 || load_ready !== 1'b0 || core_en !== 1'b0 || core_clr !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: state=%0d rdy=%0b en=%0b clr=%0b required 0 0 0 0",
               state, load_ready, core_en, core_clr);
    end
    checks++;
    if (prog_loaded !== 1'b0 || timeout !== 1'b0 || instr_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_status: loaded=%0b timeout=%0b count=%0d required 0 0 0",
               prog_loaded, timeout, instr_count);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    checks++;
    if (load_ready !== 1'b1 || state !== 3'd0) begin
      errors++;
      $display("FAIL reset_ready: rdy=%0b state=%0d required 1 0", load_ready, state);
    end
  endtask

  task automatic test_load3();
    logic [11:0] exp;
    send_word(12'h905, 1'b0);
    send_word(12'hB01, 1'b0);
    send_word(12'h000, 1'b1);
    checks++;
    if (prog_loaded !== 1'b1 || state !== 3'd0 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL load3_status: loaded=%0b state=%0d rdy=%0b required 1 0 0",
               prog_loaded, state, load_ready);
    end
    pc_force = 1'b1;
    for (int p = 0; p < 16; p++) begin
      pc_force_val = 4'(p);
      exp = (p == 0) ? 12'h905 : (p == 1) ? 12'hB01 : 12'h000;
      #1;
      checks++;
      if (core_instr !== exp) begin
        errors++;
        $display("FAIL load3_mem[%0d]: got %h required %h", p, core_instr, exp);
      end
    end
    pc_force = 1'b0;
  endtask

  task automatic test_run();
    int clr_n = 0, en_n = 0, first_clr = -1, first_en = -1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (core_clr) begin
        clr_n++;
        if (first_clr < 0) first_clr = c;
      end
      if (core_en) begin
        en_n++;
        if (first_en < 0) first_en = c;
      end
    end
    cycle();
    checks++;
    if (clr_n != 1 || first_clr != 0) begin
      errors++;
      $display("FAIL run_clr: pulses=%0d at=%0d required 1 at 0", clr_n, first_clr);
    end
    checks++;
    if (en_n != 2 || first_en != 1) begin
      errors++;
      $display("FAIL run_en: cycles=%0d first=%0d required 2 first 1", en_n, first_en);
    end
    checks++;
    if (state !== 3'd5 || instr_count !== 8'd2 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL run_done: state=%0d count=%0d timeout=%0b required 5 2 0",
               state, instr_count, timeout);
    end
  endtask

  task automatic test_stop_step();
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    checks++;
    if (state !== 3'd4 || instr_count !== 8'd1 || core_en !== 1'b0) begin
      errors++;
      $display("FAIL stop_pause: state=%0d count=%0d en=%0b required 4 1 0",
               state, instr_count, core_en);
    end
    step = 1'b1;
    #1;
    checks++;
    if (core_en !== 1'b1) begin
      errors++;
      $display("FAIL step1_en: en=%0b required 1", core_en);
    end
    cycle();
    step = 1'b0;
    checks++;
    if (state !== 3'd4 || instr_count !== 8'd2) begin
      errors++;
      $display("FAIL step1_state: state=%0d count=%0d required 4 2", state, instr_count);
    end
    step = 1'b1;
    #1;
    checks++;
    if (core_en !== 1'b0) begin
      errors++;
      $display("FAIL step2_en: en=%0b required 0", core_en);
    end
    cycle();
    step = 1'b0;
    checks++;
    if (state !== 3'd5 || instr_count !== 8'd2) begin
      errors++;
      $display("FAIL step2_done: state=%0d count=%0d required 5 2", state, instr_count);
    end
  endtask

  task automatic test_timeout();
    int en_n = 0;
    logic done = 1'b0;
    send_word(12'h901, 1'b0);
    send_word(12'h00F, 1'b1);
    checks++;
    if (prog_loaded !== 1'b1 || state !== 3'd0) begin
      errors++;
      $display("FAIL reload: loaded=%0b state=%0d required 1 0", prog_loaded, state);
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (core_en) en_n++;
      if (state == 3'd5) done = 1'b1;
    end
    cycle();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout_wait: state=%0d required 5 within 40 cycles", state);
    end
    checks++;
    if (en_n != 10 || instr_count !== 8'd10 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_done: en=%0d count=%0d timeout=%0b required 10 10 1",
               en_n, instr_count, timeout);
    end
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    checks++;
    if (state !== 3'd3 || core_en !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: state=%0d en=%0b required 3 1", state, core_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || core_en !== 1'b0 || core_clr !== 1'b0 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ctrl: state=%0d en=%0b clr=%0b rdy=%0b required 0 0 0 0",
               state, core_en, core_clr, load_ready);
    end
    checks++;
    if (prog_loaded !== 1'b0 || timeout !== 1'b0 || instr_count !== 8'd0) begin
      errors++;
      $display("FAIL midrst_status: loaded=%0b timeout=%0b count=%0d required 0 0 0",
               prog_loaded, timeout, instr_count);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b1;
    cycle();
    cycle();
    start = 1'b0;
    checks++;
    if (state !== 3'd0 || core_clr !== 1'b0 || prog_loaded !== 1'b0) begin
      errors++;
      $display("FAIL midrst_start: state=%0d clr=%0b loaded=%0b required 0 0 0",
               state, core_clr, prog_loaded);
    end
  endtask

  task automatic test_fill();
    int acc = 0;
    logic ready_after = 1'b1;
    logic [11:0] w;
    for (int i = 0; i < 17; i++) begin
      w = 12'h300 + 12'(i);
      load_valid = 1'b1;
      load_data  = w;
      load_last  = 1'b0;
      @(negedge clk);
      if (load_ready) acc++;
      if (i == 16) ready_after = load_ready;
      cycle();
    end
    load_valid = 1'b0;
    checks++;
    if (acc != 16 || ready_after !== 1'b0) begin
      errors++;
      $display("FAIL fill_accept: accepted=%0d rdy=%0b required 16 0", acc, ready_after);
    end
    checks++;
    if (prog_loaded !== 1'b1 || state !== 3'd0) begin
      errors++;
      $display("FAIL fill_status: loaded=%0b state=%0d required 1 0", prog_loaded, state);
    end
    pc_force = 1'b1;
    for (int p = 0; p < 16; p++) begin
      pc_force_val = 4'(p);
      w = 12'h300 + 12'(p);
      #1;
      checks++;
      if (core_instr !== w) begin
        errors++;
        $display("FAIL fill_mem[%0d]: got %h required %h", p, core_instr, w);
      end
    end
    pc_force = 1'b0;
  endtask

`ifdef E15_BREAKPOINT_EN
  task automatic test_breakpoint();
    logic paused = 1'b0;
    bp_valid = 1'b1;
    bp_addr  = 4'd3;
    start    = 1'b1;
    cycle();
    start    = 1'b0;
    for (int c = 0; c < 20 && !paused; c++) begin
      @(negedge clk);
      if (state == 3'd4) paused = 1'b1;
    end
    cycle();
    checks++;
    if (!paused || instr_count !== 8'd3 || bp_hit !== 1'b1 || model_pc !== 4'd3) begin
      errors++;
      $display("FAIL bp_stop: paused=%0b count=%0d hit=%0b pc=%0d required 1 3 1 3",
               paused, instr_count, bp_hit, model_pc);
    end
    step = 1'b1;
    #1;
    checks++;
    if (core_en !== 1'b1) begin
      errors++;
      $display("FAIL bp_step_en: en=%0b required 1", core_en);
    end
    cycle();
    step = 1'b0;
    checks++;
    if (instr_count !== 8'd4 || bp_hit !== 1'b0 || state !== 3'd4) begin
      errors++;
      $display("FAIL bp_step: count=%0d hit=%0b state=%0d required 4 0 4",
               instr_count, bp_hit, state);
    end
    bp_valid = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load3();
    test_run();
    test_stop_step();
    test_timeout();
    test_mid_reset();
    test_fill();
`ifdef E15_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
